mm2s_rd_arbiter: RTL and testbench
==================================

# mm2s_rd_arbiter

Two-requester arbiter that shares one AXI4 read master (AR + R channels) between two mm2s-style line readers, e.g. two display/video read channels fetching from the same DDR port. AR requests are granted round-robin and registered onto the master port. Read-data beats are routed back to the owning requester in issue order through an in-order grant FIFO. Multiple bursts may be outstanding on the shared port.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, address width on all AR ports
- C_M_AXI_DATA_WIDTH, 32, data width on all R ports (8..1024, power of 2)
- C_MAX_OUTSTANDING, 4, max bursts in flight on master port (power of 2, ≥2)
- clk  in  1  sole clock; all ports synchronous to rising edge
- reset  in  1  synchronous, active-high reset
- s0_axi_araddr / s1_axi_araddr  in  C_M_AXI_ADDR_WIDTH  requester burst address
- s0_axi_arlen / s1_axi_arlen  in  8  requester burst length − 1
- s0_axi_arvalid / s1_axi_arvalid  in  1  requester AR valid
- s0_axi_arready / s1_axi_arready  out  1  AR accepted this cycle
- s0_axi_rdata / s1_axi_rdata  out  C_M_AXI_DATA_WIDTH  routed read data
- s0_axi_rresp / s1_axi_rresp  out  2  routed response
- s0_axi_rlast / s1_axi_rlast  out  1  routed last beat
- s0_axi_rvalid / s1_axi_rvalid  out  1  routed beat valid
- s0_axi_rready / s1_axi_rready  in  1  requester ready
- m_axi_araddr, m_axi_arlen  out  ADDR / 8  registered granted request
- m_axi_arsize  out  3  constant log2(C_M_AXI_DATA_WIDTH/8)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1;  m_axi_arready  in  1
- m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid  in;  m_axi_rready  out
- err_rlast  out  1  sticky burst-length error (see Configuration)

## Operation
- AR stage: one output register (m_axi_ar*, m_axi_arvalid). It is "free" when m_axi_arvalid=0, or when m_axi_arvalid&m_axi_arready this cycle.
- Grant occurs when the AR stage is free, the grant FIFO is not full, and at least one sX_axi_arvalid=1.
- Round-robin: one priority bit holds the last granted requester; the other requester wins on contention. A lone requester always wins.
- On grant, sX_axi_arready=1 (combinational, same cycle). addr/len load into the AR register and m_axi_arvalid=1 next cycle. Granted id + arlen are pushed into the grant FIFO on the m_axi_arvalid&m_axi_arready handshake.
- The FIFO's full check uses registered occupancy plus any pending AR register. This guarantees ≤C_MAX_OUTSTANDING bursts. A same-cycle pop does not free a grant slot.
- R routing is steered by the FIFO head id h:
  - sh_axi_rvalid = m_axi_rvalid & head_valid
  - m_axi_rready = head_valid & sh_axi_rready
  - rdata/rresp/rlast pass through to both requesters (rvalid gates them).
  - The non-head requester sees rvalid=0.
- FIFO pops on m_axi_rvalid & m_axi_rready & m_axi_rlast.
- FIFO empty: m_axi_rready=0; stray beats stall on the master port.
- Simultaneous FIFO push and pop is legal; occupancy is unchanged.

## Timing
- Reset values:
  - m_axi_arvalid=0, m_axi_araddr=0, m_axi_arlen=0
  - sX_axi_arready=0, sX_axi_rvalid=0, m_axi_rready=0
  - FIFO empty, priority points to requester 0 (s0 wins first contention), err_rlast=0
- AR latency: sX_axi_arvalid high at cycle N with a free stage → arready at N → m_axi_arvalid at N+1.
- Back-to-back: with m_axi_arready held 1, one grant per cycle until the FIFO is full.
- R path is purely combinational: zero added latency, full throughput.
- m_axi_ar* remain stable while m_axi_arvalid=1 & m_axi_arready=0.
- Reset mid-burst discards all FIFO state. The AXI slave must be reset in the same cycle.

## Configuration
- MM2S_RD_ARB_RLAST_CHECK_EN defined:
  - The FIFO also stores arlen; a beat counter tracks the head burst.
  - err_rlast sets (sticky until reset) when m_axi_rlast arrives on beat ≠ arlen, or is absent on beat arlen.
  - The FIFO pops on m_axi_rlast regardless.
- Not defined: no length storage or counter; err_rlast tied 0.

## Structure
- Shared package mm2s_pkg: AXI_BURST_INCR constant, requester id type (1 bit), and the log2 function used for arsize and the FIFO pointer width.
- One sub-module: mm2s_grant_fifo, a synchronous FIFO of depth C_MAX_OUTSTANDING with width id(+8 when check enabled), exposing full/empty/count.

## Test plan
- Single requester: s0 issues addr 0x3FF80000 len 3; slave returns 4 beats → m_axi_arvalid 1 cycle after s0_axi_arready; s0 receives 4 beats, rlast on 4th; s1 rvalid never 1.
- Contention: s0 and s1 both arvalid continuously, m_axi_arready=1 → master AR sequence s0,s1,s0,s1; R beats routed to matching requester in issue order.
- Outstanding limit: C_MAX_OUTSTANDING=4, slave withholds R → exactly 4 AR handshakes, then both sX_axi_arready stay 0 until the first rlast pop.
- Backpressure: m_axi_arready=0 for 5 cycles → m_axi_araddr/arlen stable; random sX_axi_rready stalls m_axi_rready beat-for-beat, no beat lost or duplicated.
- Reset mid-operation: assert reset with 2 bursts in flight → next cycle all outputs at reset values, FIFO empty, next grant goes to s0.
- With MM2S_RD_ARB_RLAST_CHECK_EN: len 3 burst with rlast on beat 2 → err_rlast=1 the cycle after and stays 1; without the macro err_rlast stays 0.

Source files
------------

// File: rtl/mm2s_pkg.sv
// Shared types and helpers for the mm2s read arbiter slice.
package mm2s_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef logic req_id_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mm2s_grant_fifo.sv
// In-order grant FIFO: remembers which requester owns each burst in flight.
module mm2s_grant_fifo
    import mm2s_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mm2s_rd_arbiter.sv
// Round-robin two-requester AXI4 read arbiter with in-order R steering.
// Optional burst-length checking: define MM2S_RD_ARB_RLAST_CHECK_EN.
module mm2s_rd_arbiter
    import mm2s_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_MAX_OUTSTANDING  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [7:0]                    s0_axi_arlen,
    input  logic                          s0_axi_arvalid,
    output logic                          s0_axi_arready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [1:0]                    s0_axi_rresp,
    output logic                          s0_axi_rlast,
    output logic                          s0_axi_rvalid,
    input  logic                          s0_axi_rready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [7:0]                    s1_axi_arlen,
    input  logic                          s1_axi_arvalid,
    output logic                          s1_axi_arready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [1:0]                    s1_axi_rresp,
    output logic                          s1_axi_rlast,
    output logic                          s1_axi_rvalid,
    input  logic                          s1_axi_rready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic                          err_rlast
);

    localparam int CW = clog2(C_MAX_OUTSTANDING) + 1;
`ifdef MM2S_RD_ARB_RLAST_CHECK_EN
    localparam int FW = 9;
`else
    localparam int FW = 1;
`endif

    logic          prio_last;
    req_id_t       ar_id;
    logic          ar_free;
    logic          slot_ok;
    logic          can_grant;
    logic          grant0;
    logic          grant1;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic [FW-1:0] fifo_din;
    logic [FW-1:0] fifo_dout;
    logic          head_valid;
    req_id_t       head_id;

    // The pending AR register counts as an occupied slot before its push.
    always_comb begin
        ar_free   = ~m_axi_arvalid | m_axi_arready;
        slot_ok   = ~fifo_full &
                    ~(m_axi_arvalid &
                      (fifo_count == CW'(C_MAX_OUTSTANDING - 1)));
        can_grant = ~reset & ar_free & slot_ok;
        grant0    = can_grant & s0_axi_arvalid &
                    (~s1_axi_arvalid | prio_last);
        grant1    = can_grant & s1_axi_arvalid &
                    (~s0_axi_arvalid | ~prio_last);
    end

    assign s0_axi_arready = grant0;
    assign s1_axi_arready = grant1;
    assign m_axi_arsize   = 3'(clog2(C_M_AXI_DATA_WIDTH / 8));
    assign m_axi_arburst  = AXI_BURST_INCR;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            ar_id         <= 1'b0;
            prio_last     <= 1'b1;
        end else if (grant0 | grant1) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= grant1 ? s1_axi_araddr : s0_axi_araddr;
            m_axi_arlen   <= grant1 ? s1_axi_arlen : s0_axi_arlen;
            ar_id         <= grant1;
            prio_last     <= grant1;
        end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
        end
    end

    assign fifo_push = m_axi_arvalid & m_axi_arready;

    mm2s_grant_fifo #(
        .DEPTH (C_MAX_OUTSTANDING),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_valid = ~fifo_empty & ~reset;
    assign head_id    = fifo_dout[0];

    assign m_axi_rready  = head_valid &
                           (head_id ? s1_axi_rready : s0_axi_rready);
    assign s0_axi_rvalid = m_axi_rvalid & head_valid & ~head_id;
    assign s1_axi_rvalid = m_axi_rvalid & head_valid & head_id;
    assign s0_axi_rdata  = m_axi_rdata;
    assign s1_axi_rdata  = m_axi_rdata;
    assign s0_axi_rresp  = m_axi_rresp;
    assign s1_axi_rresp  = m_axi_rresp;
    assign s0_axi_rlast  = m_axi_rlast;
    assign s1_axi_rlast  = m_axi_rlast;
    assign fifo_pop      = m_axi_rvalid & m_axi_rready & m_axi_rlast;

`ifdef MM2S_RD_ARB_RLAST_CHECK_EN
    logic [7:0] beat_cnt;
    logic [7:0] head_len;

    assign fifo_din = {m_axi_arlen, ar_id};
    assign head_len = fifo_dout[8:1];

    // rlast is trusted for the pop; the counter only flags disagreement.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt  <= '0;
            err_rlast <= 1'b0;
        end else if (m_axi_rvalid & m_axi_rready) begin
            if (m_axi_rlast) begin
                beat_cnt <= '0;
                if (beat_cnt != head_len) err_rlast <= 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_cnt == head_len) err_rlast <= 1'b1;
            end
        end
    end
`else
    assign fifo_din  = ar_id;
    assign err_rlast = 1'b0;
`endif

endmodule

// File: tb/tb_mm2s_rd_arbiter.sv
// Directed self-checking bench for mm2s_rd_arbiter.
module tb_mm2s_rd_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] s0_axi_araddr, s1_axi_araddr;
    logic [7:0]  s0_axi_arlen, s1_axi_arlen;
    logic        s0_axi_arvalid, s1_axi_arvalid;
    logic        s0_axi_arready, s1_axi_arready;
    logic [31:0] s0_axi_rdata, s1_axi_rdata;
    logic [1:0]  s0_axi_rresp, s1_axi_rresp;
    logic        s0_axi_rlast, s1_axi_rlast;
    logic        s0_axi_rvalid, s1_axi_rvalid;
    logic        s0_axi_rready, s1_axi_rready;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic        err_rlast;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] bd [3] = '{32'hA0, 32'hA1, 32'hB0};
    logic        bl [3] = '{1'b0, 1'b1, 1'b1};
    logic        bh [3] = '{1'b1, 1'b1, 1'b0};
    logic [6:0]  pat = 7'b1010010;
    logic        exp_err;

    mm2s_rd_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .s0_axi_araddr  (s0_axi_araddr),
        .s0_axi_arlen   (s0_axi_arlen),
        .s0_axi_arvalid (s0_axi_arvalid),
        .s0_axi_arready (s0_axi_arready),
        .s0_axi_rdata   (s0_axi_rdata),
        .s0_axi_rresp   (s0_axi_rresp),
        .s0_axi_rlast   (s0_axi_rlast),
        .s0_axi_rvalid  (s0_axi_rvalid),
        .s0_axi_rready  (s0_axi_rready),
        .s1_axi_araddr  (s1_axi_araddr),
        .s1_axi_arlen   (s1_axi_arlen),
        .s1_axi_arvalid (s1_axi_arvalid),
        .s1_axi_arready (s1_axi_arready),
        .s1_axi_rdata   (s1_axi_rdata),
        .s1_axi_rresp   (s1_axi_rresp),
        .s1_axi_rlast   (s1_axi_rlast),
        .s1_axi_rvalid  (s1_axi_rvalid),
        .s1_axi_rready  (s1_axi_rready),
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arlen    (m_axi_arlen),
        .m_axi_arsize   (m_axi_arsize),
        .m_axi_arburst  (m_axi_arburst),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .m_axi_rdata    (m_axi_rdata),
        .m_axi_rresp    (m_axi_rresp),
        .m_axi_rlast    (m_axi_rlast),
        .m_axi_rvalid   (m_axi_rvalid),
        .m_axi_rready   (m_axi_rready),
        .err_rlast      (err_rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        s0_axi_araddr  = '0;
        s0_axi_arlen   = '0;
        s0_axi_arvalid = 1'b0;
        s1_axi_araddr  = '0;
        s1_axi_arlen   = '0;
        s1_axi_arvalid = 1'b0;
        s0_axi_rready  = 1'b1;
        s1_axi_rready  = 1'b1;
        m_axi_arready  = 1'b0;
        m_axi_rdata    = '0;
        m_axi_rresp    = '0;
        m_axi_rlast    = 1'b0;
        m_axi_rvalid   = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
`ifdef MM2S_RD_ARB_RLAST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        reset = 1'b1;
        idle();
        reset_dut();
        #1;
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arlen", m_axi_arlen, 0);
        chk("rst_s0_arready", s0_axi_arready, 0);
        chk("rst_s1_arready", s1_axi_arready, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_err", err_rlast, 0);
        chk("arsize", m_axi_arsize, 2);
        chk("arburst", m_axi_arburst, 1);

        // single requester
        @(negedge clk);
        s0_axi_arvalid = 1'b1;
        s0_axi_araddr  = 32'h3FF80000;
        s0_axi_arlen   = 8'd3;
        #1;
        chk("one_arready", s0_axi_arready, 1);
        chk("one_arvalid_pre", m_axi_arvalid, 0);
        @(negedge clk);
        s0_axi_arvalid = 1'b0;
        m_axi_arready  = 1'b1;
        #1;
        chk("one_arvalid", m_axi_arvalid, 1);
        chk("one_araddr", m_axi_araddr, 32'h3FF80000);
        chk("one_arlen", m_axi_arlen, 3);
        @(negedge clk);
        m_axi_arready = 1'b0;
        #1;
        chk("one_arvalid_drop", m_axi_arvalid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 32'hD000 + 32'(i);
            m_axi_rresp  = (i == 1) ? 2'b10 : 2'b00;
            m_axi_rlast  = (i == 3);
            #1;
            chk("one_s0_rvalid", s0_axi_rvalid, 1);
            chk("one_s1_rvalid", s1_axi_rvalid, 0);
            chk("one_rdata", s0_axi_rdata, 32'hD000 + 32'(i));
            chk("one_rresp", s0_axi_rresp, (i == 1) ? 2 : 0);
            chk("one_rlast", s0_axi_rlast, (i == 3) ? 1 : 0);
            chk("one_rready", m_axi_rready, 1);
        end
        @(negedge clk);
        #1;
        chk("one_empty_rready", m_axi_rready, 0);
        chk("one_empty_rvalid", s0_axi_rvalid, 0);
        idle();

        // contention and outstanding limit
        reset_dut();
        s0_axi_araddr  = 32'h1000;
        s1_axi_araddr  = 32'h2000;
        s0_axi_arvalid = 1'b1;
        s1_axi_arvalid = 1'b1;
        m_axi_arready  = 1'b1;
        #1;
        chk("ct_g0_s0", s0_axi_arready, 1);
        chk("ct_g0_s1", s1_axi_arready, 0);
        @(negedge clk);
        #1;
        chk("ct_g1_s1", s1_axi_arready, 1);
        chk("ct_g1_s0", s0_axi_arready, 0);
        chk("ct_ar0", m_axi_araddr, 32'h1000);
        @(negedge clk);
        #1;
        chk("ct_g2_s0", s0_axi_arready, 1);
        chk("ct_ar1", m_axi_araddr, 32'h2000);
        @(negedge clk);
        #1;
        chk("ct_g3_s1", s1_axi_arready, 1);
        chk("ct_ar2", m_axi_araddr, 32'h1000);
        @(negedge clk);
        #1;
        chk("lim_s0", s0_axi_arready, 0);
        chk("lim_s1", s1_axi_arready, 0);
        chk("ct_ar3", m_axi_araddr, 32'h2000);
        chk("ct_ar3_v", m_axi_arvalid, 1);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("lim_hold_s0", s0_axi_arready, 0);
            chk("lim_hold_s1", s1_axi_arready, 0);
            chk("lim_hold_v", m_axi_arvalid, 0);
        end
        @(negedge clk);
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        m_axi_rdata  = 32'h10;
        #1;
        chk("ct_b0_s0", s0_axi_rvalid, 1);
        chk("ct_b0_s1", s1_axi_rvalid, 0);
        chk("ct_b0_data", s0_axi_rdata, 32'h10);
        chk("lim_pop_same", s0_axi_arready | s1_axi_arready, 0);
        @(negedge clk);
        s1_axi_arvalid = 1'b0;
        m_axi_rdata    = 32'h11;
        #1;
        chk("lim_freed", s0_axi_arready, 1);
        chk("ct_b1_s1", s1_axi_rvalid, 1);
        chk("ct_b1_s0", s0_axi_rvalid, 0);
        chk("ct_b1_data", s1_axi_rdata, 32'h11);
        @(negedge clk);
        s0_axi_arvalid = 1'b0;
        m_axi_rdata    = 32'h12;
        #1;
        chk("ct_b2_s0", s0_axi_rvalid, 1);
        chk("ct_b2_s1", s1_axi_rvalid, 0);
        chk("ct_ar4", m_axi_araddr, 32'h1000);
        chk("ct_ar4_v", m_axi_arvalid, 1);
        @(negedge clk);
        m_axi_rdata = 32'h13;
        #1;
        chk("ct_b3_s1", s1_axi_rvalid, 1);
        chk("ct_b3_s0", s0_axi_rvalid, 0);
        @(negedge clk);
        m_axi_rdata = 32'h14;
        #1;
        chk("ct_b4_s0", s0_axi_rvalid, 1);
        chk("ct_b4_s1", s1_axi_rvalid, 0);
        @(negedge clk);
        #1;
        chk("ct_stray_rready", m_axi_rready, 0);
        chk("ct_stray_s0", s0_axi_rvalid, 0);
        chk("ct_stray_s1", s1_axi_rvalid, 0);

        // AR backpressure and R stalls
        @(negedge clk);
        idle();
        s1_axi_arvalid = 1'b1;
        s1_axi_araddr  = 32'h5000;
        s1_axi_arlen   = 8'd1;
        #1;
        chk("bp_s1_grant", s1_axi_arready, 1);
        @(negedge clk);
        s1_axi_arvalid = 1'b0;
        s0_axi_arvalid = 1'b1;
        s0_axi_araddr  = 32'h6000;
        #1;
        chk("bp_blocked", s0_axi_arready, 0);
        chk("bp_addr0", m_axi_araddr, 32'h5000);
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("bp_hold_v", m_axi_arvalid, 1);
            chk("bp_hold_addr", m_axi_araddr, 32'h5000);
            chk("bp_hold_len", m_axi_arlen, 1);
            chk("bp_hold_gnt", s0_axi_arready, 0);
        end
        @(negedge clk);
        m_axi_arready = 1'b1;
        #1;
        chk("bp_release", s0_axi_arready, 1);
        @(negedge clk);
        s0_axi_arvalid = 1'b0;
        #1;
        chk("bp_addr1", m_axi_araddr, 32'h6000);
        chk("bp_len1", m_axi_arlen, 0);
        @(negedge clk);
        m_axi_arready = 1'b0;
        begin
            int b;
            b = 0;
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = bd[b];
                m_axi_rlast  = bl[b];
                s1_axi_rready = bh[b] ? pat[k] : ~pat[k];
                s0_axi_rready = bh[b] ? ~pat[k] : pat[k];
                #1;
                chk("bp_rready", m_axi_rready, pat[k]);
                chk("bp_rv_head",
                    bh[b] ? s1_axi_rvalid : s0_axi_rvalid, 1);
                chk("bp_rv_other",
                    bh[b] ? s0_axi_rvalid : s1_axi_rvalid, 0);
                chk("bp_rdata",
                    bh[b] ? s1_axi_rdata : s0_axi_rdata, bd[b]);
                if (pat[k]) b++;
            end
        end
        @(negedge clk);
        s0_axi_rready = 1'b1;
        s1_axi_rready = 1'b1;
        #1;
        chk("bp_drained", m_axi_rready, 0);

        // reset with two bursts in flight
        reset_dut();
        s1_axi_arvalid = 1'b1;
        s1_axi_araddr  = 32'h7000;
        m_axi_arready  = 1'b1;
        #1;
        chk("mr_s1", s1_axi_arready, 1);
        @(negedge clk);
        s1_axi_arvalid = 1'b0;
        s0_axi_arvalid = 1'b1;
        s0_axi_araddr  = 32'h8000;
        s0_axi_arlen   = 8'd5;
        #1;
        chk("mr_s0", s0_axi_arready, 1);
        @(negedge clk);
        s0_axi_arvalid = 1'b0;
        @(negedge clk);
        m_axi_arready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        #1;
        chk("mr_arvalid", m_axi_arvalid, 0);
        chk("mr_araddr", m_axi_araddr, 0);
        chk("mr_arlen", m_axi_arlen, 0);
        chk("mr_rready", m_axi_rready, 0);
        chk("mr_s0_rvalid", s0_axi_rvalid, 0);
        chk("mr_s1_rvalid", s1_axi_rvalid, 0);
        @(negedge clk);
        m_axi_rvalid   = 1'b0;
        s0_axi_arvalid = 1'b1;
        s1_axi_arvalid = 1'b1;
        #1;
        chk("mr_prio_s0", s0_axi_arready, 1);
        chk("mr_prio_s1", s1_axi_arready, 0);

        // short burst: rlast one beat early
        reset_dut();
        s0_axi_arvalid = 1'b1;
        s0_axi_araddr  = 32'h9000;
        s0_axi_arlen   = 8'd3;
        m_axi_arready  = 1'b1;
        @(negedge clk);
        s0_axi_arvalid = 1'b0;
        @(negedge clk);
        m_axi_arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 32'(i);
            m_axi_rlast  = (i == 2);
            #1;
            chk("rl_s0_rvalid", s0_axi_rvalid, 1);
            chk("rl_err_before", err_rlast, 0);
        end
        @(negedge clk);
        #1;
        chk("rl_err", err_rlast, exp_err);
        chk("rl_stray_stall", m_axi_rready, 0);
        m_axi_rvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rl_err_sticky", err_rlast, exp_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
